// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: message widths and small arithmetic helpers
// used by both the variable node and check node units.
package ldpc_pkg;

    localparam int LLR_W      = 8;
    localparam int MSG_W      = 8;
    localparam int VN_DEG_MAX = 12;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic signed [31:0] sext(input logic [31:0] value, input int in_w);
        logic [31:0] sh;
        sh = value << (32 - in_w);
        return $signed(sh) >>> (32 - in_w);
    endfunction

    // Clamp to +/-(2^(out_w-1)-1); the most negative code is never produced.
    function automatic logic signed [31:0] sat_sym(input logic [31:0] value, input int in_w,
                                                   input int out_w);
        logic signed [31:0] v;
        logic signed [31:0] lim;
        v   = sext(value, in_w);
        lim = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        if (v > lim) begin
            return lim;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/vnu_msg_buf.sv
// Holds the r_i messages of the node in flight for the subtraction pass.
// Synchronous write, combinational read.
module vnu_msg_buf #(
    parameter int DEPTH = 12,
    parameter int W     = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i <= LAST_ADDR)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = (rd_addr_i <= LAST_ADDR) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/vnu_serial.sv
// Bit-serial LDPC variable node: accumulates l + sum(r_i), then streams
// q_i = sat(s - r_i) in arrival order together with the hard decision.
module vnu_serial
    import ldpc_pkg::*;
#(
    parameter int data_w = LLR_W,
    parameter int D_MAX  = VN_DEG_MAX,
    parameter int out_w  = MSG_W,
    parameter bit SAT_EN = 1'b1,
    localparam int ext_w = clog2(D_MAX + 1),
    localparam int sum_w = data_w + ext_w,
    localparam int DEG_W = clog2(D_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DEG_W-1:0]  deg,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic [data_w-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [out_w-1:0]  out_data,
    output logic              out_last,
    output logic              dec,
    output logic              dec_valid,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    logic [1:0]              state_q, state_d;
    logic signed [sum_w-1:0] sum_q, sum_d;
    logic [DEG_W-1:0]        deg_q, deg_d;
    logic [DEG_W-1:0]        cnt_q, cnt_d;
    logic [DEG_W-1:0]        idx_q, idx_d;
    logic [out_w-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    dec_q, dec_d;
    logic                    dec_valid_q, dec_valid_d;
    logic                    err_q, err_d;
    logic                    in_ready_q;

    logic                    accept;
    logic                    deg_ok;
    logic                    wr_en;
    logic [DEG_W-1:0]        rd_addr;
    logic [data_w-1:0]       rd_data;
    logic [data_w-1:0]       sub_r;

    function automatic logic [out_w-1:0] q_of(input logic signed [sum_w-1:0] s,
                                              input logic [data_w-1:0] r);
        logic signed [31:0] diff;
        logic signed [31:0] q;
        diff = sext(32'(unsigned'(s)), sum_w) - sext(32'(r), data_w);
        q    = SAT_EN ? sat_sym(diff, 32, out_w) : diff;
        return q[out_w-1:0];
    endfunction

    vnu_msg_buf #(
        .DEPTH (D_MAX),
        .W     (data_w),
        .AW    (DEG_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (cnt_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign accept = in_valid & in_ready_q;
    assign deg_ok = (deg != '0) && (deg <= DEG_W'(D_MAX));

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        deg_d       = deg_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        dec_d       = dec_q;
        dec_valid_d = dec_valid_q;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        rd_addr     = '0;
        sub_r       = rd_data;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_first && deg_ok) begin
                        sum_d   = sum_w'(sext(32'(in_data), data_w));
                        deg_d   = deg;
                        cnt_d   = '0;
                        state_d = S_ACC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACC: begin
                if (accept && in_first) begin
                    // Abort restarts immediately on the new first beat when it is usable.
                    err_d = 1'b1;
                    if (deg_ok) begin
                        sum_d = sum_w'(sext(32'(in_data), data_w));
                        deg_d = deg;
                        cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (accept) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + sum_w'(sext(32'(in_data), data_w));
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == deg_q - 1'b1) begin
                        // buf[0] is still being written when deg is 1, so bypass it.
                        if (cnt_q == '0) begin
                            sub_r = in_data;
                        end
                        state_d     = S_EMIT;
                        dec_d       = sum_d[sum_w-1];
                        dec_valid_d = 1'b1;
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = (deg_q == DEG_W'(1));
                        out_data_d  = q_of(sum_d, sub_r);
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        dec_valid_d = 1'b0;
                        idx_d       = '0;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        rd_addr    = idx_q + 1'b1;
                        out_data_d = q_of(sum_q, rd_data);
                        out_last_d = ((idx_q + 1'b1) == (deg_q - 1'b1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            deg_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            dec_q       <= 1'b0;
            dec_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            deg_q       <= deg_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            dec_q       <= dec_d;
            dec_valid_q <= dec_valid_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d != S_EMIT);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign dec       = dec_q;
    assign dec_valid = dec_valid_q;
    assign err       = err_q;

endmodule

// File: doc/vnu_serial.md
Name: vnu_serial

Overview:
- Bit-serial successor to the combinational variable node unit in the LDPC decoder.
- Accepts one channel LLR, then a runtime-selectable number (deg ≤ D_MAX) of check-to-variable messages, one beat per cycle over a valid/ready stream.
- Accumulates the total, then streams the extrinsic messages q_i = sat(s − r_i) and the hard decision back out.
- Sits between the message memory read port and the CNU input FIFO; supports irregular codes with one instance per column group.

Parameters:
- data_w, 8, width of input LLR and r messages (two's complement).
- D_MAX, 12, maximum variable-node degree; sets buffer depth.
- out_w, 8, width of output q messages; must satisfy out_w ≤ data_w + ext_w.
- SAT_EN, 1, 1 = symmetric saturation of q to ±(2^(out_w−1)−1); 0 = truncate to the low out_w bits.
- ext_w, clog2(D_MAX+1), derived guard bits; sum_w = data_w + ext_w.
- DEG_W, clog2(D_MAX+1), derived width of deg.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- deg  in  DEG_W  node degree; sampled on the accepted first beat.
- in_valid  in  1  input beat valid.
- in_first  in  1  beat carries channel LLR l (start of node).
- in_data  in  data_w  l or r_i.
- in_ready  out  1  block can accept a beat.
- out_valid  out  1  q beat valid.
- out_ready  in  1  downstream accepts q.
- out_data  out  out_w  q_i, in arrival order of r_i.
- out_last  out  1  marks the q_(deg−1) beat.
- dec  out  1  hard decision, sign of s (1 = negative).
- dec_valid  out  1  dec is valid for the current node.
- err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while in reset; out_valid=0, out_data=0, out_last=0, dec=0, dec_valid=0, err=0; sum, count and index cleared. Buffer contents are don't-care.
- All arithmetic is two's complement. Every operand is sign-extended to sum_w. s can never overflow sum_w.
- s − r_i is computed in sum_w bits, which always fits. Saturation, or truncation when SAT_EN=0, is applied only to out_data.
- FSM IDLE: in_ready=1.
  - Beat accepted with in_first=1 and 1 ≤ deg ≤ D_MAX: sum ← sext(l); latch deg; cnt ← 0; go to ACC.
  - Accepted beat with in_first=0, or deg outside 1..D_MAX: beat is dropped; err=1 for one cycle; stay in IDLE.
- FSM ACC: in_ready=1.
  - Beat accepted with in_first=0: buf[cnt] ← r; sum ← sum + sext(r); cnt++.
  - When the deg-th r is accepted: go to EMIT next cycle. dec ← sign of the final sum; dec_valid ← 1.
  - Beat accepted with in_first=1: abort the node; err=1; restart as an IDLE first-beat acceptance in the same cycle (new l, new deg).
- FSM EMIT: in_ready=0; out_valid=1; out_data = sat(s − buf[idx]); out_last = (idx == deg−1).
  - Handshake (out_valid & out_ready): idx++.
  - Handshake on the out_last beat: go to IDLE; dec_valid ← 0; out_valid ← 0.
  - out_ready low: out_data, out_last and idx hold stable.
- Latency: first q is valid the cycle after the last r is accepted.
- Throughput: a node occupies (deg+1) + deg cycles with no backpressure. There is no overlap between nodes.
- dec holds its value after dec_valid drops, until the next node completes ACC.
- out_data is registered from a buffer read, so out_data is a function of registered state only; there is no combinational path from in_* to out_*.
- When SAT_EN=1, q = −2^(out_w−1) is never produced.

Decomposition:
- Shared package ldpc_pkg:
  - clog2 function.
  - sat_sym(value, in_w, out_w) function.
  - sign-extension helper.
  - Message width constants, shared with the CNU.
- One sub-module, vnu_msg_buf: D_MAX × data_w register file with one synchronous write port and one combinational read port. It holds the r_i values for the subtraction pass.
- The FSM, accumulator and output register stay in vnu_serial.

Test Plan:
- Basic: data_w=8, deg=3; l=10, r=5,−3,7 → s=19; q=14,22,12; out_last on the 3rd beat; dec=0; dec_valid high during EMIT.
- Negative and decision: deg=2; l=−20, r=4,−1 → s=−17; q=−21,−16; dec=1.
- Saturation: deg=12; l=127, all r=127 → s=1651; every q=127 (SAT_EN=1). All r=−128, l=−128 → every q=−127; dec=1.
- Backpressure: deg=4; hold out_ready=0 for 5 cycles mid-EMIT → out_data and idx are stable, in_ready=0, no beats are lost; the sequence completes in order.
- Protocol errors:
  - deg=0 with in_first=1 → err pulse, stays in IDLE, no output.
  - in_first=0 in IDLE → err, beat dropped.
  - in_first=1 after 2 of 4 r beats → err, node restarts with new l; only the new node's q values are emitted.
- Reset mid-EMIT: drop rst_n after 1 of 3 q beats → out_valid=0, dec_valid=0 immediately. After release, a new node (l=1, r=1, deg=1) yields q=1, dec=0.
